// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler: round-robin write-back arbiter and busy scoreboard for the register file write port.
// Optional REGFILE_WB_CHECK_EN adds a sticky sb_err flag for write-backs to registers not marked busy.
module regfile_wb_scheduler #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rs1,
    input  logic [AW-1:0]   issue_rs2,
    input  logic [AW-1:0]   issue_rd,
    output logic            issue_ready,
    input  logic            alu_wb_valid,
    input  logic [AW-1:0]   alu_wb_rd,
    input  logic [XLEN-1:0] alu_wb_data,
    output logic            alu_wb_ready,
    input  logic            mem_wb_valid,
    input  logic [AW-1:0]   mem_wb_rd,
    input  logic [XLEN-1:0] mem_wb_data,
    output logic            mem_wb_ready,
    output logic            rf_we,
    output logic [AW-1:0]   rf_w,
    output logic [XLEN-1:0] rf_data_in,
`ifdef REGFILE_WB_CHECK_EN
    output logic            sb_err,
`endif
    output logic [NREG-1:0] busy_mask
);
    localparam logic [NREG-1:0] ONE = {{(NREG-1){1'b0}}, 1'b1};
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_set;
    logic [NREG-1:0] busy_clr;
    logic            ptr;
    logic            gnt;
    logic [AW-1:0]   gnt_rd;
    logic [XLEN-1:0] gnt_data;
    assign busy_mask = busy;
    // ptr = 0 favours the ALU when both requesters are valid
    always_comb begin
        issue_ready  = ~(issue_valid & (busy[issue_rs1] | busy[issue_rs2] | busy[issue_rd]));
        alu_wb_ready = alu_wb_valid & (~mem_wb_valid | ~ptr);
        mem_wb_ready = mem_wb_valid & (~alu_wb_valid | ptr);
        gnt          = alu_wb_ready | mem_wb_ready;
        gnt_rd       = alu_wb_ready ? alu_wb_rd : mem_wb_rd;
        gnt_data     = alu_wb_ready ? alu_wb_data : mem_wb_data;
        busy_set     = (issue_valid & issue_ready & (issue_rd != '0)) ? (ONE << issue_rd) : '0;
        busy_clr     = rf_we ? (ONE << rf_w) : '0;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            busy       <= '0;
            ptr        <= 1'b0;
            rf_we      <= 1'b0;
            rf_w       <= '0;
            rf_data_in <= '0;
        end else begin
            busy  <= ((busy & ~busy_clr) | busy_set) & ~ONE;
            rf_we <= gnt & (gnt_rd != '0);
            if (gnt) begin
                ptr        <= alu_wb_ready;
                rf_w       <= gnt_rd;
                rf_data_in <= gnt_data;
            end
        end
    end
`ifdef REGFILE_WB_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset)
            sb_err <= 1'b0;
        else if (gnt & (gnt_rd != '0) & ~busy[gnt_rd])
            sb_err <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// tb_regfile_wb_scheduler: directed stimulus checked every cycle against a set-of-pending-writes model,
// plus hand-computed literal expectations; sb_err is checked when REGFILE_WB_CHECK_EN is defined.
module tb_regfile_wb_scheduler;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;
    logic clk = 1'b0;
    logic reset;
    logic issue_valid;
    logic [AW-1:0] issue_rs1, issue_rs2, issue_rd;
    logic issue_ready;
    logic alu_wb_valid;
    logic [AW-1:0] alu_wb_rd;
    logic [XLEN-1:0] alu_wb_data;
    logic alu_wb_ready;
    logic mem_wb_valid;
    logic [AW-1:0] mem_wb_rd;
    logic [XLEN-1:0] mem_wb_data;
    logic mem_wb_ready;
    logic rf_we;
    logic [AW-1:0] rf_w;
    logic [XLEN-1:0] rf_data_in;
    logic [NREG-1:0] busy_mask;
`ifdef REGFILE_WB_CHECK_EN
    logic sb_err;
`endif
    int total = 0;
    int bad = 0;
    bit chk_on = 0;

    always #5 clk = ~clk;

    regfile_wb_scheduler #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rd(issue_rd), .issue_ready(issue_ready),
        .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
        .alu_wb_ready(alu_wb_ready),
        .mem_wb_valid(mem_wb_valid), .mem_wb_rd(mem_wb_rd), .mem_wb_data(mem_wb_data),
        .mem_wb_ready(mem_wb_ready),
        .rf_we(rf_we), .rf_w(rf_w), .rf_data_in(rf_data_in),
`ifdef REGFILE_WB_CHECK_EN
        .sb_err(sb_err),
`endif
        .busy_mask(busy_mask)
    );

    // model: which registers have a write outstanding, who won last, what the port shows
    bit pend[NREG];
    string last_winner = "mem";
    bit m_we = 0;
    int m_w = 0;
    logic [31:0] m_d = 0;
    bit m_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic string winner();
        if (alu_wb_valid && mem_wb_valid) return (last_winner == "alu") ? "mem" : "alu";
        if (alu_wb_valid) return "alu";
        if (mem_wb_valid) return "mem";
        return "none";
    endfunction

    function automatic bit stall();
        return issue_valid && (pend[issue_rs1] || pend[issue_rs2] || pend[issue_rd]);
    endfunction

    function automatic logic [31:0] pend_word();
        logic [31:0] v = 0;
        for (int i = 1; i < NREG; i++) if (pend[i]) v = v + (32'd1 << i);
        return v;
    endfunction

    always @(posedge clk) begin : model
        string w;
        bit acc;
        int rd;
        logic [31:0] d;
        w = winner();
        acc = !stall() && issue_valid && issue_rd != 0;
        rd = (w == "alu") ? int'(alu_wb_rd) : int'(mem_wb_rd);
        d = (w == "alu") ? alu_wb_data : mem_wb_data;
        if (reset) begin
            for (int i = 0; i < NREG; i++) pend[i] = 0;
            last_winner = "mem";
            m_we = 0; m_w = 0; m_d = 0; m_err = 0;
        end else begin
            if (w != "none" && rd != 0 && !pend[rd]) m_err = 1;
            if (m_we) pend[m_w] = 0;
            if (acc) pend[issue_rd] = 1;
            if (w != "none") begin
                m_we = (rd != 0); m_w = rd; m_d = d; last_winner = w;
            end else m_we = 0;
        end
    end

    always @(negedge clk) begin : compare
        string w;
        if (chk_on) begin
            w = winner();
            chk("issue_ready", issue_ready, !stall());
            chk("alu_wb_ready", alu_wb_ready, w == "alu");
            chk("mem_wb_ready", mem_wb_ready, w == "mem");
            chk("rf_we", rf_we, m_we);
            chk("rf_w", rf_w, m_w);
            chk("rf_data_in", rf_data_in, m_d);
            chk("busy_mask", busy_mask, pend_word());
`ifdef REGFILE_WB_CHECK_EN
            chk("sb_err", sb_err, m_err);
`endif
        end
    end

    task automatic idle();
        issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
        alu_wb_valid = 0; alu_wb_rd = 0; alu_wb_data = 0;
        mem_wb_valid = 0; mem_wb_rd = 0; mem_wb_data = 0;
    endtask
    task automatic cyc();
        @(posedge clk); #1; idle();
    endtask
    task automatic settle();
        @(negedge clk); #1;
    endtask
    task automatic iss(input int rs1, input int rs2, input int rd);
        issue_valid = 1; issue_rs1 = AW'(rs1); issue_rs2 = AW'(rs2); issue_rd = AW'(rd);
    endtask
    task automatic alu(input int rd, input logic [31:0] d);
        alu_wb_valid = 1; alu_wb_rd = AW'(rd); alu_wb_data = d;
    endtask
    task automatic mem(input int rd, input logic [31:0] d);
        mem_wb_valid = 1; mem_wb_rd = AW'(rd); mem_wb_data = d;
    endtask

    initial begin
        idle();
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        chk_on = 1;
        settle();
        chk("rst busy_mask", busy_mask, 0);
        chk("rst rf_we", rf_we, 0);
        chk("rst rf_w", rf_w, 0);
        chk("rst rf_data_in", rf_data_in, 0);
`ifdef REGFILE_WB_CHECK_EN
        chk("rst sb_err", sb_err, 0);
`endif
        // RAW stall and release
        cyc(); iss(0, 0, 5); settle(); chk("t1 issue x5", issue_ready, 1);
        cyc(); iss(5, 0, 0); settle(); chk("t1 busy x5", busy_mask, 32'h20); chk("t1 raw stall", issue_ready, 0);
        cyc(); iss(5, 0, 0); alu(5, 32'h1234); settle(); chk("t1 alu ready", alu_wb_ready, 1);
        cyc(); iss(5, 0, 0); settle();
        chk("t1 rf_we", rf_we, 1); chk("t1 rf_w", rf_w, 5); chk("t1 data", rf_data_in, 32'h1234);
        chk("t1 still stalled", issue_ready, 0);
        cyc(); iss(5, 0, 0); settle();
        chk("t1 busy clear", busy_mask, 0); chk("t1 released", issue_ready, 1); chk("t1 we low", rf_we, 0);
        // round robin with both requesters valid
        cyc(); reset = 1;
        cyc(); reset = 0;
        for (int i = 1; i <= 4; i++) begin cyc(); iss(0, 0, i); end
        cyc(); alu(1, 32'hA1); mem(2, 32'hB2); settle();
        chk("t2 busy 1..4", busy_mask, 32'h1E); chk("t2 g0 alu", alu_wb_ready, 1); chk("t2 g0 mem", mem_wb_ready, 0);
        cyc(); alu(3, 32'hA3); mem(2, 32'hB2); settle();
        chk("t2 g1 mem", mem_wb_ready, 1); chk("t2 g1 alu", alu_wb_ready, 0);
        chk("t2 w0", rf_w, 1); chk("t2 d0", rf_data_in, 32'hA1); chk("t2 we0", rf_we, 1);
        cyc(); alu(3, 32'hA3); mem(4, 32'hB4); settle();
        chk("t2 g2 alu", alu_wb_ready, 1); chk("t2 w1", rf_w, 2); chk("t2 d1", rf_data_in, 32'hB2); chk("t2 we1", rf_we, 1);
        cyc(); alu(0, 32'hFFFF_FFFF); mem(4, 32'hB4); settle();
        chk("t2 g3 mem", mem_wb_ready, 1); chk("t2 w2", rf_w, 3); chk("t2 we2", rf_we, 1);
        cyc(); alu(0, 32'hFFFF_FFFF); settle();
        chk("t2 g4 alu", alu_wb_ready, 1); chk("t2 w3", rf_w, 4); chk("t2 we3", rf_we, 1); chk("t2 busy x4", busy_mask, 32'h10);
        cyc(); settle();
        chk("t2 rd0 we", rf_we, 0); chk("t2 rd0 w", rf_w, 0); chk("t2 rd0 d", rf_data_in, 32'hFFFF_FFFF); chk("t2 busy 0", busy_mask, 0);
        // rd=0 write-back leaves an unrelated busy bit alone
        cyc(); iss(0, 0, 10);
        cyc(); alu(0, 32'hFFFF_FFFF); settle(); chk("t3 alu ready", alu_wb_ready, 1); chk("t3 busy", busy_mask, 32'h400);
        cyc(); settle(); chk("t3 we", rf_we, 0); chk("t3 busy kept", busy_mask, 32'h400);
        // WAW stall on x7
        cyc(); iss(0, 0, 7); settle(); chk("t4 first", issue_ready, 1);
        cyc(); iss(0, 0, 7); alu(7, 32'h77); settle(); chk("t4 waw stall", issue_ready, 0); chk("t4 alu ready", alu_wb_ready, 1);
        cyc(); iss(0, 0, 7); settle(); chk("t4 stall in we", issue_ready, 0); chk("t4 we", rf_we, 1); chk("t4 w", rf_w, 7);
        cyc(); iss(0, 0, 7); settle(); chk("t4 accept", issue_ready, 1); chk("t4 busy", busy_mask, 32'h400);
        cyc(); settle(); chk("t4 rebusy", busy_mask, 32'h480);
        cyc(); mem(7, 32'h7);
        cyc(); mem(10, 32'hA);
        cyc(); cyc(); settle(); chk("t4 drained", busy_mask, 0);
        // reset drops an accepted load write
        cyc(); iss(0, 0, 3);
        cyc(); mem(3, 32'h33); settle(); chk("t5 mem ready", mem_wb_ready, 1);
        cyc(); reset = 1;
        cyc(); reset = 0; settle();
        chk("t5 we dropped", rf_we, 0); chk("t5 busy", busy_mask, 0);
        cyc(); alu(0, 32'h1); mem(0, 32'h2); settle(); chk("t5 alu first", alu_wb_ready, 1); chk("t5 mem wait", mem_wb_ready, 0);
        cyc(); reset = 1;
        cyc(); reset = 0; alu(0, 32'h6); mem(0, 32'h7); settle();
        chk("t5 ptr reset alu", alu_wb_ready, 1); chk("t5 ptr reset mem", mem_wb_ready, 0);
        // write-back to a non-busy register still lands
        cyc(); mem(9, 32'h99); settle(); chk("t6 mem ready", mem_wb_ready, 1);
        cyc(); settle(); chk("t6 we", rf_we, 1); chk("t6 w", rf_w, 9); chk("t6 d", rf_data_in, 32'h99);
        cyc(); cyc(); settle();
`ifdef REGFILE_WB_CHECK_EN
        chk("t6 sb_err sticky", sb_err, 1);
        cyc(); reset = 1;
        cyc(); reset = 0; settle(); chk("t6 sb_err cleared", sb_err, 0);
`endif
        cyc();
        chk_on = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
